// File: rtl/rv32e_pkg.sv
// Shared RV32E definitions used by the load/store unit: funct3 width codes,
// LSU error codes, LSU state encoding and request legality helpers.
package rv32e_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_ERR_OK       = 2'b00,
      LSU_ERR_MISALIGN = 2'b01,
      LSU_ERR_FUNCT3   = 2'b10,
      LSU_ERR_TIMEOUT  = 2'b11
   } lsu_err_e;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'b00,
      LSU_ACCESS = 2'b01,
      LSU_RESP   = 2'b10
   } lsu_state_e;

   // Unsigned widths only exist for loads; reserved codes are always illegal.
   function automatic logic lsu_funct3_illegal(input logic [2:0] funct3, input logic we);
      logic illegal;
      case (funct3)
         F3_B, F3_H, F3_W: illegal = 1'b0;
         F3_BU, F3_HU:     illegal = we;
         default:          illegal = 1'b1;
      endcase
      return illegal;
   endfunction

   // Natural alignment: halfwords on even addresses, words on multiples of 4.
   function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      logic mis;
      case (funct3)
         F3_H, F3_HU: mis = addr_lo[0];
         F3_W:        mis = |addr_lo;
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/rv32e_lsu_if.sv
// Word-addressed data memory bus between the LSU (master) and memory (slave).
interface rv32e_lsu_if;
   logic        mem_req;
   logic        mem_write_en;
   logic [31:0] mem_addr_bus;
   logic [3:0]  mem_byte_en;
   logic [31:0] mem_write_data_bus;
   logic        mem_ack;
   logic [31:0] mem_read_data_bus;

   modport master (
      output mem_req, mem_write_en, mem_addr_bus, mem_byte_en, mem_write_data_bus,
      input  mem_ack, mem_read_data_bus
   );

   modport slave (
      input  mem_req, mem_write_en, mem_addr_bus, mem_byte_en, mem_write_data_bus,
      output mem_ack, mem_read_data_bus
   );
endinterface

// File: rtl/rv32e_lsu_align.sv
// Lane logic for the LSU: byte enables, store lane replication and load
// lane extraction with sign/zero extension. Purely combinational.
module rv32e_lsu_align
   import rv32e_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Select the addressed byte and halfword lanes of the read word.
   always_comb begin
      byte_s = 8'h00;
      case (offset)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = 8'h00;
      endcase
      if (offset[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
   end

   // Per-width enables, replicated store data and extended load data.
   always_comb begin
      byte_en   = 4'b0000;
      wdata_rep = 32'h0000_0000;
      load_data = 32'h0000_0000;
      case (funct3)
         F3_B: begin
            byte_en   = 4'b0001 << offset;
            wdata_rep = {4{wdata[7:0]}};
            load_data = {{24{byte_s[7]}}, byte_s};
         end
         F3_BU: begin
            byte_en   = 4'b0001 << offset;
            wdata_rep = {4{wdata[7:0]}};
            load_data = {24'h00_0000, byte_s};
         end
         F3_H: begin
            byte_en   = 4'b0011 << offset;
            wdata_rep = {2{wdata[15:0]}};
            load_data = {{16{half_s[15]}}, half_s};
         end
         F3_HU: begin
            byte_en   = 4'b0011 << offset;
            wdata_rep = {2{wdata[15:0]}};
            load_data = {16'h0000, half_s};
         end
         F3_W: begin
            byte_en   = 4'b1111;
            wdata_rep = wdata;
            load_data = rdata;
         end
         default: begin
            byte_en   = 4'b0000;
            wdata_rep = 32'h0000_0000;
            load_data = 32'h0000_0000;
         end
      endcase
   end

endmodule

// File: rtl/rv32e_lsu.sv
// RV32E load/store unit: one access in flight, request validation, memory
// handshake with wait-state timeout and a one-cycle response pulse.
module rv32e_lsu
   import rv32e_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_err,
   rv32e_lsu_if.master mem
);

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   lsu_state_e  state_r;
   logic        req_ready_r;
   logic        resp_valid_r;
   logic [31:0] resp_rdata_r;
   logic [1:0]  resp_err_r;
   logic        mem_req_r;
   logic        mem_we_r;
   logic [31:0] mem_addr_r;
   logic [3:0]  mem_be_r;
   logic [31:0] mem_wdata_r;
   logic [2:0]  funct3_r;
   logic [1:0]  offset_r;
   logic [7:0]  timeout_cnt_r;

   logic [2:0]  sel_funct3_s;
   logic [1:0]  sel_offset_s;
   logic [3:0]  byte_en_s;
   logic [31:0] wdata_rep_s;
   logic [31:0] load_data_s;
   logic [7:0]  cnt_inc_s;

   // Lane logic looks at the live request while idle, the captured one afterwards.
   always_comb begin
      if (state_r == LSU_IDLE) begin
         sel_funct3_s = req_funct3;
         sel_offset_s = req_addr[1:0];
      end else begin
         sel_funct3_s = funct3_r;
         sel_offset_s = offset_r;
      end
      cnt_inc_s = timeout_cnt_r + 8'd1;
   end

   rv32e_lsu_align u_align (
      .funct3    (sel_funct3_s),
      .offset    (sel_offset_s),
      .wdata     (req_wdata),
      .rdata     (mem.mem_read_data_bus),
      .byte_en   (byte_en_s),
      .wdata_rep (wdata_rep_s),
      .load_data (load_data_s)
   );

   // Access FSM with all outputs registered; reset discards any access in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r       <= LSU_IDLE;
         req_ready_r   <= 1'b1;
         resp_valid_r  <= 1'b0;
         resp_rdata_r  <= 32'h0000_0000;
         resp_err_r    <= LSU_ERR_OK;
         mem_req_r     <= 1'b0;
         mem_we_r      <= 1'b0;
         mem_addr_r    <= 32'h0000_0000;
         mem_be_r      <= 4'b0000;
         mem_wdata_r   <= 32'h0000_0000;
         funct3_r      <= 3'b000;
         offset_r      <= 2'b00;
         timeout_cnt_r <= 8'd0;
      end else begin
         case (state_r)
            LSU_IDLE: begin
               if (req_valid) begin
                  funct3_r     <= req_funct3;
                  offset_r     <= req_addr[1:0];
                  req_ready_r  <= 1'b0;
                  resp_rdata_r <= 32'h0000_0000;
                  if (lsu_funct3_illegal(req_funct3, req_we)) begin
                     resp_err_r   <= LSU_ERR_FUNCT3;
                     resp_valid_r <= 1'b1;
                     state_r      <= LSU_RESP;
                  end else if (lsu_misaligned(req_funct3, req_addr[1:0])) begin
                     resp_err_r   <= LSU_ERR_MISALIGN;
                     resp_valid_r <= 1'b1;
                     state_r      <= LSU_RESP;
                  end else begin
                     mem_req_r     <= 1'b1;
                     mem_we_r      <= req_we;
                     mem_addr_r    <= {req_addr[31:2], 2'b00};
                     mem_be_r      <= byte_en_s;
                     mem_wdata_r   <= wdata_rep_s;
                     timeout_cnt_r <= 8'd0;
                     state_r       <= LSU_ACCESS;
                  end
               end
            end
            LSU_ACCESS: begin
               // Ack is checked first so an ack on the limit cycle still succeeds.
               if (mem.mem_ack || (cnt_inc_s == TIMEOUT_LIMIT)) begin
                  mem_req_r    <= 1'b0;
                  mem_we_r     <= 1'b0;
                  mem_addr_r   <= 32'h0000_0000;
                  mem_be_r     <= 4'b0000;
                  mem_wdata_r  <= 32'h0000_0000;
                  resp_valid_r <= 1'b1;
                  state_r      <= LSU_RESP;
                  if (mem.mem_ack) begin
                     resp_err_r   <= LSU_ERR_OK;
                     resp_rdata_r <= mem_we_r ? 32'h0000_0000 : load_data_s;
                  end else begin
                     resp_err_r   <= LSU_ERR_TIMEOUT;
                     resp_rdata_r <= 32'h0000_0000;
                  end
               end else begin
                  timeout_cnt_r <= cnt_inc_s;
               end
            end
            LSU_RESP: begin
               resp_valid_r <= 1'b0;
               resp_rdata_r <= 32'h0000_0000;
               resp_err_r   <= LSU_ERR_OK;
               req_ready_r  <= 1'b1;
               state_r      <= LSU_IDLE;
            end
            default: begin
               state_r      <= LSU_IDLE;
               req_ready_r  <= 1'b1;
               resp_valid_r <= 1'b0;
               mem_req_r    <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready              = req_ready_r;
   assign resp_valid             = resp_valid_r;
   assign resp_rdata             = resp_rdata_r;
   assign resp_err               = resp_err_r;
   assign mem.mem_req            = mem_req_r;
   assign mem.mem_write_en       = mem_we_r;
   assign mem.mem_addr_bus       = mem_addr_r;
   assign mem.mem_byte_en        = mem_be_r;
   assign mem.mem_write_data_bus = mem_wdata_r;

endmodule

// File: tb/tb_rv32e_lsu.sv
// Self-checking bench for rv32e_lsu: directed cases plus randomized accesses
// checked against a byte-level reference model of loads, stores and timeouts.
module tb_rv32e_lsu;

   localparam int TMO = 4;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;

   int n_cmp;
   int n_bad;

   rv32e_lsu_if mem_if ();

   rv32e_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem        (mem_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: what a given access should produce, from the ISA rules.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] word, input int waits,
                        output logic [1:0] err, output logic [3:0] be, output logic [31:0] bus_wd,
                        output logic [31:0] rd, output int nreq);
      int size;
      int off;
      logic [31:0] v;
      logic [31:0] lane;
      size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : (f3 == 3'd2) ? 4 : 0;
      off  = int'(addr % 32'd4);
      if (size == 0 || (we && f3[2])) err = 2'b10;
      else if ((addr % size) != 0)     err = 2'b01;
      else if (waits >= TMO)           err = 2'b11;
      else                             err = 2'b00;
      nreq = (err == 2'b01 || err == 2'b10) ? 0 : (waits >= TMO ? TMO : waits + 1);
      be   = 4'(((1 << size) - 1) << off);
      lane = word >> (8 * off);
      if (size == 1) begin
         v = lane & 32'hFF;
         if (!f3[2] && v >= 32'd128) v = v + 32'hFFFF_FF00;
         bus_wd = (wdata & 32'hFF) * 32'h0101_0101;
      end else if (size == 2) begin
         v = lane & 32'hFFFF;
         if (!f3[2] && v >= 32'd32768) v = v + 32'hFFFF_0000;
         bus_wd = (wdata & 32'hFFFF) * 32'h0001_0001;
      end else begin
         v = word;
         bus_wd = wdata;
      end
      rd = (err == 2'b00 && !we) ? v : 32'h0;
   endtask

   // Issue one access, play the memory with 'waits' wait states, check everything.
   task automatic access(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] word, input int waits);
      logic [1:0]  e_err;
      logic [3:0]  e_be;
      logic [31:0] e_wd;
      logic [31:0] e_rd;
      int          e_nreq;
      int          nreq;
      int          lat;
      bit          got_resp;
      model(we, f3, addr, wdata, word, waits, e_err, e_be, e_wd, e_rd, e_nreq);
      for (int i = 0; i < 10 && !req_ready; i++) step();
      check({name, "_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      step();
      req_valid = 1'b0;
      nreq = 0; lat = 0; got_resp = 1'b0;
      for (int c = 0; c < 300; c++) begin
         mem_if.mem_ack = 1'b0;
         if (resp_valid) begin
            got_resp = 1'b1; lat = c;
            break;
         end
         if (mem_if.mem_req) begin
            nreq++;
            check({name, "_addr"}, mem_if.mem_addr_bus, addr & 32'hFFFF_FFFC);
            check({name, "_be"}, 32'(mem_if.mem_byte_en), 32'(e_be));
            check({name, "_we"}, 32'(mem_if.mem_write_en), 32'(we));
            if (we) check({name, "_wdata"}, mem_if.mem_write_data_bus, e_wd);
            if (nreq - 1 == waits) begin
               mem_if.mem_ack = 1'b1;
               mem_if.mem_read_data_bus = word;
            end
         end
         step();
      end
      mem_if.mem_ack = 1'b0;
      check({name, "_resp_seen"}, 32'(got_resp), 32'd1);
      check({name, "_latency"}, 32'(lat), 32'(e_nreq));
      check({name, "_nreq"}, 32'(nreq), 32'(e_nreq));
      check({name, "_err"}, 32'(resp_err), 32'(e_err));
      check({name, "_rdata"}, resp_rdata, e_rd);
      check({name, "_req_at_resp"}, 32'(mem_if.mem_req), 32'd0);
      step();
      check({name, "_pulse"}, 32'(resp_valid), 32'd0);
      check({name, "_ready_after"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int stray;
      n_cmp = 0; n_bad = 0;
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'h0; req_wdata = 32'h0;
      mem_if.mem_ack = 1'b0; mem_if.mem_read_data_bus = 32'h0;
      step(); step();
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_err", 32'(resp_err), 32'd0);
      check("rst_mem_req", 32'(mem_if.mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_if.mem_write_en), 32'd0);
      check("rst_mem_addr", mem_if.mem_addr_bus, 32'h0);
      check("rst_mem_be", 32'(mem_if.mem_byte_en), 32'd0);
      check("rst_mem_wd", mem_if.mem_write_data_bus, 32'h0);
      reset = 1'b1;
      step();

      access("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
      access("lb_103", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_7F01, 1);
      access("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_7F01, 0);
      access("sh_202", 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 3);
      access("lw_101", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
      access("sw_f3_100", 1'b1, 3'b100, 32'h200, 32'h5555_AAAA, 32'h0, 0);
      access("lh_f3_011", 1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 0);
      access("lw_tmo", 1'b0, 3'b010, 32'h300, 32'h0, 32'h1111_2222, 50);

      // Stray ack two cycles after the timeout response must be ignored.
      step();
      mem_if.mem_ack = 1'b1; mem_if.mem_read_data_bus = 32'hFFFF_FFFF;
      step();
      mem_if.mem_ack = 1'b0;
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         if (resp_valid || mem_if.mem_req) stray++;
         step();
      end
      check("stray_ack_quiet", 32'(stray), 32'd0);
      check("stray_ack_ready", 32'(req_ready), 32'd1);

      // Reset in the middle of an access discards it.
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
      step();
      req_valid = 1'b0;
      step();
      check("abort_mem_req_before", 32'(mem_if.mem_req), 32'd1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("abort_mem_req", 32'(mem_if.mem_req), 32'd0);
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd1);
      check("abort_be", 32'(mem_if.mem_byte_en), 32'd0);
      check("abort_addr", mem_if.mem_addr_bus, 32'h0);
      stray = 0;
      for (int i = 0; i < 5; i++) begin
         if (resp_valid) stray++;
         step();
      end
      check("abort_no_resp", 32'(stray), 32'd0);
      access("lhu_006", 1'b0, 3'b101, 32'h006, 32'h0, 32'h8001_1234, 1);

      // Randomized accesses: all funct3 codes, random offsets and wait states.
      for (int n = 0; n < 60; n++) begin
         access("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                ($urandom & 32'h0000_0FFF), $urandom, $urandom, int'($urandom_range(0, 5)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
